// File: rtl/dmem_dump_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_dump_ctrl
//
// Purpose:
//   Owns the data-memory port and shares it between the CPU MEM stage and the
//   debug dump engine. While idle, the CPU request passes straight through to
//   data memory. On a dump request the CPU is stalled and memory words
//   0..DUMP_WORDS-1 are read back and streamed to the UART transmitter.
//   Each word is sent as DATA_LENGTH/8 bytes, most significant byte first,
//   over a valid/ready handshake.
//
// Ports:
//   i_clk, i_rst      clock (posedge) and asynchronous active-low reset
//   i_cpu_*           MEM-stage request: address, we, re, size, store data
//   o_cpu_data        load data returned to the CPU (wired from i_mem_data)
//   o_cpu_stall       high whenever the dump engine owns the memory port
//   i_cpu_halted      CPU has retired HALT; the dump only reads once this is set
//   i_dump_start      single-cycle dump request from the debug unit
//   o_dump_busy       high in every state except IDLE
//   o_dump_done       single-cycle pulse after the last byte was accepted
//   o_tx_data/valid   byte stream towards the UART TX
//   i_tx_ready        UART TX takes the byte when valid && ready
//   o_mem_*           data-memory request (address, we, re, size, write data)
//   i_mem_data        read data, valid the cycle after the address is driven
// -----------------------------------------------------------------------------
module dmem_dump_ctrl #(
  parameter int ADDR_LENGTH = 32,
  parameter int DATA_LENGTH = 32,
  parameter int DUMP_WORDS  = 1024
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [ADDR_LENGTH-1:0] i_cpu_addr,
  input  logic                   i_cpu_we,
  input  logic                   i_cpu_re,
  input  logic [4:0]             i_cpu_size,
  input  logic [DATA_LENGTH-1:0] i_cpu_data,
  output logic [DATA_LENGTH-1:0] o_cpu_data,
  output logic                   o_cpu_stall,
  input  logic                   i_cpu_halted,
  input  logic                   i_dump_start,
  output logic                   o_dump_busy,
  output logic                   o_dump_done,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready,
  output logic [ADDR_LENGTH-1:0] o_mem_addr,
  output logic                   o_mem_we,
  output logic                   o_mem_re,
  output logic [4:0]             o_mem_size,
  output logic [DATA_LENGTH-1:0] o_mem_data,
  input  logic [DATA_LENGTH-1:0] i_mem_data
);

  localparam int BYTES  = DATA_LENGTH / 8;
  localparam int WCNT_W = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1;
  localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(DUMP_WORDS - 1);
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_HALT,
    S_READ,
    S_LATCH,
    S_SEND,
    S_DONE
  } state_t;

  state_t                 state_reg;
  logic [WCNT_W-1:0]      word_cnt_reg;
  logic [BCNT_W-1:0]      byte_cnt_reg;
  logic [DATA_LENGTH-1:0] shift_reg;
  logic [DATA_LENGTH-1:0] shift_next;
  logic                   tx_valid_reg;
  logic                   dump_done_reg;

  // ---------------------------------------------------------------------------
  // Byte-lane shifter: every lane takes the lane below it, lane 0 fills with
  // zero, so the next byte to send always sits in the top lane.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      if (gi == 0) begin : g_fill
        assign shift_next[7:0] = 8'h00;
      end else begin : g_move
        assign shift_next[8*gi +: 8] = shift_reg[8*(gi-1) +: 8];
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Dump sequencer. tx_valid and dump_done are registered so the UART and the
  // debug unit see glitch-free handshake signals.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg     <= S_IDLE;
      word_cnt_reg  <= '0;
      byte_cnt_reg  <= '0;
      shift_reg     <= '0;
      tx_valid_reg  <= 1'b0;
      dump_done_reg <= 1'b0;
    end else begin
      dump_done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (i_dump_start) begin
            state_reg <= i_cpu_halted ? S_READ : S_WAIT_HALT;
          end
        end

        // The first cycle that sees halted already drives the read (see the
        // port mux below), so it goes straight to LATCH; this keeps the first
        // byte two cycles after halted rises.
        S_WAIT_HALT: begin
          if (i_cpu_halted) begin
            state_reg <= S_LATCH;
          end
        end

        S_READ: begin
          state_reg <= S_LATCH;
        end

        S_LATCH: begin
          shift_reg    <= i_mem_data;
          byte_cnt_reg <= '0;
          tx_valid_reg <= 1'b1;
          state_reg    <= S_SEND;
        end

        // tx_valid is always high here, so ready alone marks an accept.
        S_SEND: begin
          if (i_tx_ready) begin
            shift_reg    <= shift_next;
            byte_cnt_reg <= byte_cnt_reg + 1'b1;
            if (byte_cnt_reg == LAST_BYTE) begin
              tx_valid_reg <= 1'b0;
              if (word_cnt_reg == LAST_WORD) begin
                dump_done_reg <= 1'b1;
                state_reg     <= S_DONE;
              end else begin
                word_cnt_reg <= word_cnt_reg + 1'b1;
                state_reg    <= S_READ;
              end
            end
          end
        end

        S_DONE: begin
          word_cnt_reg <= '0;
          state_reg    <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Memory-port ownership. Outside IDLE the write enable is forced low so a
  // stalled CPU store can never reach memory while the dump runs.
  // ---------------------------------------------------------------------------
  always_comb begin
    o_mem_addr = ADDR_LENGTH'(word_cnt_reg);
    o_mem_we   = 1'b0;
    o_mem_re   = 1'b0;
    o_mem_size = 5'b00000;
    o_mem_data = '0;
    case (state_reg)
      S_IDLE: begin
        o_mem_addr = i_cpu_addr;
        o_mem_we   = i_cpu_we;
        o_mem_re   = i_cpu_re;
        o_mem_size = i_cpu_size;
        o_mem_data = i_cpu_data;
      end
      S_WAIT_HALT: begin
        o_mem_re = i_cpu_halted;
      end
      S_READ: begin
        o_mem_re = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign o_cpu_data  = i_mem_data;
  assign o_cpu_stall = (state_reg != S_IDLE);
  assign o_dump_busy = (state_reg != S_IDLE);
  assign o_dump_done = dump_done_reg;
  assign o_tx_valid  = tx_valid_reg;
  assign o_tx_data   = shift_reg[DATA_LENGTH-1 -: 8];

endmodule
